// File: rtl/hough_peak_select.sv
// Hough accumulator peak picker: streams every cell from BRAM and keeps a vote-sorted list of
// the strongest cells. Define HOUGH_SPLIT_LR_EN for separate left/right theta half-lists.
module hough_peak_select #(
  parameter int          RHOS             = 1469,
  parameter int unsigned RHO_RANGE        = 2938,
  parameter int unsigned THETAS           = 180,
  parameter int unsigned ACCUM_BUFF_WIDTH = 16,
  parameter int unsigned NUM_LANES        = 8,
  localparam int unsigned CELLS           = RHO_RANGE * THETAS,
  localparam int unsigned ADDR_W          = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic [ACCUM_BUFF_WIDTH-1:0]           i_threshold,
  output logic                                  o_rd_en,
  output logic [ADDR_W-1:0]                     o_rd_addr,
  input  logic [ACCUM_BUFF_WIDTH-1:0]           i_rd_data,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [NUM_LANES*16-1:0]               o_rhos_out,
  output logic [NUM_LANES*8-1:0]                o_thetas_out,
  output logic [NUM_LANES*ACCUM_BUFF_WIDTH-1:0] o_votes_out,
  output logic [NUM_LANES-1:0]                  o_valid_out
);

  localparam int unsigned RHO_W   = (RHO_RANGE > 1) ? $clog2(RHO_RANGE) : 1;
  localparam int unsigned THETA_W = (THETAS > 1) ? $clog2(THETAS) : 1;
  localparam logic [ADDR_W-1:0]  LastAddr  = ADDR_W'(CELLS - 1);
  localparam logic [THETA_W-1:0] LastTheta = THETA_W'(THETAS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e                      r_state, w_state_nxt;
  logic                        r_rd_en;
  logic [ADDR_W-1:0]           r_addr;
  logic [RHO_W-1:0]            r_rho;
  logic [THETA_W-1:0]          r_theta;
  logic [ACCUM_BUFF_WIDTH-1:0] r_thresh;

  // Cell coordinates travel alongside the one-cycle BRAM latency.
  logic                        r_dv;
  logic [RHO_W-1:0]            r_dv_rho;
  logic [THETA_W-1:0]          r_dv_theta;

  logic [15:0]                 r_slot_rho   [NUM_LANES];
  logic [7:0]                  r_slot_theta [NUM_LANES];
  logic [ACCUM_BUFF_WIDTH-1:0] r_slot_votes [NUM_LANES];
  logic [NUM_LANES-1:0]        r_slot_valid;

  logic [15:0]                 w_nxt_rho    [NUM_LANES];
  logic [7:0]                  w_nxt_theta  [NUM_LANES];
  logic [ACCUM_BUFF_WIDTH-1:0] w_nxt_votes  [NUM_LANES];
  logic [NUM_LANES-1:0]        w_nxt_valid;
  logic [NUM_LANES-1:0]        w_hit;

  logic                        w_cand;
  logic signed [31:0]          w_rho_full;
  logic [15:0]                 w_cand_rho;
  logic [7:0]                  w_cand_theta;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = StScan;
      StScan:  if (r_addr == LastAddr) w_state_nxt = StDrain;
      StDrain: if (r_dv) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_cand       = r_dv && (i_rd_data >= r_thresh);
  assign w_rho_full   = $signed({{(32 - RHO_W){1'b0}}, r_dv_rho}) - RHOS;
  assign w_cand_rho   = w_rho_full[15:0];
  assign w_cand_theta = 8'(r_dv_theta);

`ifdef HOUGH_SPLIT_LR_EN
  localparam logic [THETA_W-1:0] SplitTheta = THETA_W'(THETAS / 2);
  logic w_right;
  assign w_right = (r_dv_theta >= SplitTheta);
`endif

  // A slot "hits" when the candidate outranks it; the sorted list makes hits a contiguous tail,
  // so the first hit takes the new cell and every later hit takes its upper neighbour.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_slot
`ifdef HOUGH_SPLIT_LR_EN
    localparam bit First = (g == 0) || (g == int'(NUM_LANES / 2));
    logic w_en;
    assign w_en = ((g >= int'(NUM_LANES / 2)) == w_right);
`else
    localparam bit First = (g == 0);
    logic w_en;
    assign w_en = 1'b1;
`endif
    assign w_hit[g] = w_cand && w_en &&
                      (!r_slot_valid[g] || (r_slot_votes[g] < i_rd_data));

    if (First) begin : g_head
      assign w_nxt_rho[g]   = w_hit[g] ? w_cand_rho   : r_slot_rho[g];
      assign w_nxt_theta[g] = w_hit[g] ? w_cand_theta : r_slot_theta[g];
      assign w_nxt_votes[g] = w_hit[g] ? i_rd_data    : r_slot_votes[g];
      assign w_nxt_valid[g] = w_hit[g] | r_slot_valid[g];
    end else begin : g_body
      assign w_nxt_rho[g]   = !w_hit[g] ? r_slot_rho[g] :
                              (w_hit[g-1] ? r_slot_rho[g-1] : w_cand_rho);
      assign w_nxt_theta[g] = !w_hit[g] ? r_slot_theta[g] :
                              (w_hit[g-1] ? r_slot_theta[g-1] : w_cand_theta);
      assign w_nxt_votes[g] = !w_hit[g] ? r_slot_votes[g] :
                              (w_hit[g-1] ? r_slot_votes[g-1] : i_rd_data);
      assign w_nxt_valid[g] = !w_hit[g] ? r_slot_valid[g] :
                              (w_hit[g-1] ? r_slot_valid[g-1] : 1'b1);
    end

    assign o_rhos_out[g*16 +: 16]                             = r_slot_rho[g];
    assign o_thetas_out[g*8 +: 8]                             = r_slot_theta[g];
    assign o_votes_out[g*ACCUM_BUFF_WIDTH +: ACCUM_BUFF_WIDTH] = r_slot_votes[g];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_rd_en      <= 1'b0;
      r_addr       <= '0;
      r_rho        <= '0;
      r_theta      <= '0;
      r_thresh     <= '0;
      r_dv         <= 1'b0;
      r_dv_rho     <= '0;
      r_dv_theta   <= '0;
      r_slot_valid <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        r_slot_rho[i]   <= '0;
        r_slot_theta[i] <= '0;
        r_slot_votes[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_dv       <= r_rd_en;
      r_dv_rho   <= r_rho;
      r_dv_theta <= r_theta;

      if (r_dv) begin
        r_slot_valid <= w_nxt_valid;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
          r_slot_rho[i]   <= w_nxt_rho[i];
          r_slot_theta[i] <= w_nxt_theta[i];
          r_slot_votes[i] <= w_nxt_votes[i];
        end
      end

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_rd_en      <= 1'b1;
            r_addr       <= '0;
            r_rho        <= '0;
            r_theta      <= '0;
            r_thresh     <= i_threshold;
            r_slot_valid <= '0;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
              r_slot_rho[i]   <= '0;
              r_slot_theta[i] <= '0;
              r_slot_votes[i] <= '0;
            end
          end
        end
        StScan: begin
          if (r_addr == LastAddr) begin
            r_rd_en <= 1'b0;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_theta == LastTheta) begin
              r_theta <= '0;
              r_rho   <= r_rho + RHO_W'(1);
            end else begin
              r_theta <= r_theta + THETA_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_addr;
  assign o_busy      = (r_state == StScan) || (r_state == StDrain);
  assign o_done      = (r_state == StDone);
  assign o_valid_out = r_slot_valid;

endmodule

// File: tb/tb_hough_peak_select.sv
// Bench for hough_peak_select on a small accumulator; reference is a stable top-K selection.
module tb_hough_peak_select;
  localparam int RHOS      = 6;
  localparam int RHO_RANGE = 12;
  localparam int THETAS    = 16;
  localparam int AW        = 16;
  localparam int NL        = 8;
  localparam int CELLS     = RHO_RANGE * THETAS;
  localparam int ADDR_W    = $clog2(CELLS);
`ifdef HOUGH_SPLIT_LR_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, start;
  logic [AW-1:0]     threshold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [AW-1:0]     rd_data;
  logic              busy, done;
  logic [NL*16-1:0]  rhos_out;
  logic [NL*8-1:0]   thetas_out;
  logic [NL*AW-1:0]  votes_out;
  logic [NL-1:0]     valid_out;

  logic [AW-1:0] mem [CELLS];
  int  n_vec = 0;
  int  n_fail = 0;
  bit  exp_valid [NL];
  int  exp_rho   [NL];
  int  exp_theta [NL];
  int  exp_votes [NL];

  hough_peak_select #(
    .RHOS(RHOS), .RHO_RANGE(RHO_RANGE), .THETAS(THETAS),
    .ACCUM_BUFF_WIDTH(AW), .NUM_LANES(NL)
  ) dut (
    .i_clock(clk), .i_reset(reset), .i_start(start), .i_threshold(threshold),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_busy(busy), .o_done(done),
    .o_rhos_out(rhos_out), .o_thetas_out(thetas_out), .o_votes_out(votes_out),
    .o_valid_out(valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Keep the NL (or NL/2 per half) highest-vote cells, earliest scanned first among equals.
  function automatic void build_model(input int thr);
    for (int s = 0; s < NL; s++) begin
      exp_valid[s] = 1'b0; exp_rho[s] = 0; exp_theta[s] = 0; exp_votes[s] = 0;
    end
    for (int l = 0; l < (SPLIT ? 2 : 1); l++) begin
      int base = SPLIT ? l * (NL / 2) : 0;
      int size = SPLIT ? NL / 2 : NL;
      int cand[$];
      for (int a = 0; a < CELLS; a++) begin
        bit in_list = !SPLIT || (((a % THETAS) >= THETAS / 2) == (l == 1));
        if (in_list && int'(mem[a]) >= thr) cand.push_back(a);
      end
      for (int s = 0; s < size; s++) begin
        int best = 0;
        if (cand.size() == 0) break;
        for (int k = 1; k < cand.size(); k++)
          if (mem[cand[k]] > mem[cand[best]]) best = k;
        exp_valid[base+s] = 1'b1;
        exp_rho[base+s]   = (cand[best] / THETAS - RHOS) & 16'hFFFF;
        exp_theta[base+s] = cand[best] % THETAS;
        exp_votes[base+s] = int'(mem[cand[best]]);
        cand.delete(best);
      end
    end
  endfunction

  task automatic check_results(input string tag);
    for (int s = 0; s < NL; s++) begin
      check($sformatf("%s valid[%0d]", tag, s), 32'(valid_out[s]), 32'(exp_valid[s]));
      check($sformatf("%s rho[%0d]", tag, s), 32'(rhos_out[s*16 +: 16]), exp_rho[s]);
      check($sformatf("%s theta[%0d]", tag, s), 32'(thetas_out[s*8 +: 8]), exp_theta[s]);
      check($sformatf("%s votes[%0d]", tag, s), 32'(votes_out[s*AW +: AW]), exp_votes[s]);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < CELLS; a++) mem[a] = '0;
  endtask

  task automatic random_mem(input int max_v);
    for (int a = 0; a < CELLS; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, max_v)) : '0;
  endtask

  task automatic pulse_start(input int thr);
    @(posedge clk); #1;
    start = 1'b1; threshold = AW'(thr);
    @(posedge clk); #1;
    start = 1'b0; threshold = AW'($urandom);
  endtask

  // Entered one cycle after the accepting edge; optionally re-pulses start mid-scan.
  task automatic wait_done(input string tag, input int extra_at, input int extra_thr);
    int cyc = 1;
    bit seen = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (cyc <= CELLS + 10) begin
      if (done) begin seen = 1'b1; break; end
      if (cyc == extra_at) begin start = 1'b1; threshold = AW'(extra_thr); end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(CELLS + 2));
  endtask

  task automatic run_scan(input string tag, input int thr);
    pulse_start(thr);
    build_model(thr);
    wait_done(tag, -1, 0);
    check_results(tag);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1; start = 1'b0; threshold = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst rd_en", 32'(rd_en), 0);
    check("rst rd_addr", 32'(rd_addr), 0);
    check("rst valid", 32'(valid_out), 0);
    check("rst rhos", 32'(|rhos_out), 0);
    check("rst thetas", 32'(|thetas_out), 0);
    check("rst votes", 32'(|votes_out), 0);
    reset = 1'b0;

    run_scan("zero", 1);
    check("zero valid_all", 32'(valid_out), 0);

    clear_mem();
    mem[6*THETAS + 3]  = 16'd50;
    mem[9*THETAS + 11] = 16'd80;
    run_scan("two", 10);
`ifdef HOUGH_SPLIT_LR_EN
    check("two l0 rho", 32'(rhos_out[15:0]), 0);
    check("two l0 theta", 32'(thetas_out[7:0]), 3);
    check("two r0 votes", 32'(votes_out[(NL/2)*AW +: AW]), 80);
`else
    check("two s0 rho", 32'(rhos_out[15:0]), 3);
    check("two s0 theta", 32'(thetas_out[7:0]), 11);
    check("two s1 votes", 32'(votes_out[AW +: AW]), 50);
`endif
    @(posedge clk); #1;
    check_results("two hold");

    clear_mem();
    for (int a = 0; a < 10; a++) mem[a] = 16'd20;
    run_scan("ties", 20);
`ifndef HOUGH_SPLIT_LR_EN
    check("ties valid_all", 32'(valid_out), 32'(8'hFF));
    check("ties s7 theta", 32'(thetas_out[7*8 +: 8]), 7);
`endif

    random_mem(40);
    run_scan("thr0", 0);
    run_scan("thrmax", 16'hFFFF);
    check("thrmax valid_all", 32'(valid_out), 0);
    for (int r = 0; r < 4; r++) begin
      random_mem(30);
      run_scan($sformatf("rand%0d", r), $urandom_range(0, 30));
    end

    // Reset mid-scan: abort silently, then a fresh scan must be correct.
    random_mem(40);
    pulse_start(3);
    repeat (50) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort rd_en", 32'(rd_en), 0);
    check("abort valid", 32'(valid_out), 0);
    done_cnt = 0;
    repeat (CELLS + 5) begin @(posedge clk); #1; if (done) done_cnt++; end
    check("abort no_done", 32'(done_cnt), 0);
    run_scan("after_abort", 5);

    // Reset wins over a same-cycle start.
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("rst_prio busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("rst_prio idle", 32'(busy), 0);

    // A second start mid-scan must not restart or re-sample threshold.
    random_mem(40);
    pulse_start(15);
    build_model(15);
    wait_done("restart", 50, 0);
    check_results("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/hough_peak_select.md
HOUGH_PEAK_SELECT -- requirements
Module: hough_peak_select

Interface
REQ-001 Parameter RHOS, default 1469, meaning rho offset (signed rho = rho index - RHOS).
REQ-002 Parameter RHO_RANGE, default 2938, meaning number of rho rows in the accumulator.
REQ-003 Parameter THETAS, default 180, meaning theta columns per rho row (one degree each).
REQ-004 Parameter ACCUM_BUFF_WIDTH, default 16, meaning vote count width.
REQ-005 Parameter NUM_LANES, default 8, meaning total candidate slots (even, ≥2).
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse; begins a scan when idle.
REQ-009 threshold  input  ACCUM_BUFF_WIDTH  minimum vote count; sampled on accepted start.
REQ-010 rd_en  output  1  accumulator BRAM read strobe.
REQ-011 rd_addr  output  clog2(RHO_RANGE*THETAS)  address = rho_index*THETAS + theta.
REQ-012 rd_data  input  ACCUM_BUFF_WIDTH  BRAM data, valid exactly 1 cycle after rd_en.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse when results are final.
REQ-015 rhos_out  output  NUM_LANES x 16  signed rho per slot.
REQ-016 thetas_out  output  NUM_LANES x 8  theta per slot.
REQ-017 votes_out  output  NUM_LANES x ACCUM_BUFF_WIDTH  votes per slot.
REQ-018 valid_out  output  NUM_LANES  slot-occupied flags.

Function
REQ-019 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start, SCAN->DRAIN after issuing address RHO_RANGE*THETAS-1, DRAIN->DONE after last rd_data consumed, DONE->IDLE next cycle.
REQ-020 SCAN issues rd_en every cycle, theta-major inner loop: theta 0..THETAS-1 wrapping to 0 with rho index incremented, starting at address 0.
REQ-021 start while busy is ignored; threshold is not re-sampled.
REQ-022 Each returned cell with rd_data ≥ threshold (unsigned compare) is a candidate; cells below are discarded.
REQ-023 Slot list is kept sorted by votes descending; a candidate inserts at first slot whose votes are strictly lower or which is invalid, shifting lower slots down and dropping the last.
REQ-024 Ties keep the earlier-scanned cell ahead (later candidate inserts below equals).
REQ-025 Insertion completes in the cycle rd_data is presented; one candidate per cycle, no stall.
REQ-026 rhos_out = rho_index - RHOS, 16-bit two's complement; thetas_out = theta index.
REQ-027 On accepted start all valid_out clear and slot fields zero.
REQ-028 done asserts exactly RHO_RANGE*THETAS + 2 cycles after the cycle start is accepted; outputs hold until next accepted start or reset.
REQ-029 threshold = 0 makes every cell a candidate; threshold above all data leaves valid_out = 0 at done.

Reset
REQ-030 reset forces IDLE; busy, done, rd_en, rd_addr, valid_out, rhos_out, thetas_out, votes_out all 0.
REQ-031 reset mid-scan aborts with no done pulse; an in-flight rd_data is ignored.
REQ-032 reset has priority over start in the same cycle.

Configuration
REQ-033 Macro HOUGH_SPLIT_LR_EN defined: slots 0..NUM_LANES/2-1 form the left list (theta < THETAS/2), slots NUM_LANES/2..NUM_LANES-1 the right list (theta ≥ THETAS/2), each independently sorted per REQ-023/024.
REQ-034 Macro undefined: one list of NUM_LANES slots over all thetas.

Verification
REQ-035 Accumulator all zero, threshold 1 -> done at cycle RHO_RANGE*THETAS+2, valid_out = 0.
REQ-036 Cells (rho idx 1469, theta 45)=50 and (1500, 135)=80, rest 0, threshold 10 -> slot0 rho 31 theta 135 votes 80, slot1 rho 0 theta 45 votes 50 (macro off).
REQ-037 Same data with HOUGH_SPLIT_LR_EN -> slot0 rho 0 theta 45 votes 50, slot NUM_LANES/2 rho 31 theta 135 votes 80.
REQ-038 Ten cells of 20 votes at addresses 0..9, threshold 20 -> slots hold the first 8 scanned (theta 0..7, rho -1469), valid_out = all ones (macro off).
REQ-039 reset asserted at scan cycle 1000, then new start with threshold 5 -> no done for first scan; second scan completes with correct results.
REQ-040 start pulsed again at scan cycle 500 with threshold 0 -> ignored; results reflect original threshold.
